mmio_responder: RTL and testbench

Responder end of the processor's data-memory bus. It decodes the I/O window at IO_BASE and serves LED, switch, switch-edge, cycle-counter and display registers. All other addresses pass through to dmem. It sits between the datapath's DM_* signals and dmem, replacing ad-hoc LED/switch decode at the top level.

---
 rtl/mmio_responder.sv | 156 +++++++++++++++
 tb/tb_mmio_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - data-memory bus responder with LED/switch/cycle/display I/O window
//
// Decodes a 256-byte I/O window at IO_BASE and serves the register file below.
// All other addresses pass through to dmem.
//
//   offset 0x00 LED      RW   [15:0]
//   offset 0x08 SW       RO   debounced switches
//   offset 0x10 SW_EDGE  RW1C rising-edge flags of SW
//   offset 0x18 CYCLE    RW   free-running cycle counter
//   offset 0x20 DISP     RW   [15:0], four BCD digits
//
// Ports:
//   clk            processor clock (mclk)
//   reset          synchronous, active-high
//   addr           bus address from datapath
//   writeData      bus write data from datapath
//   memWrite       bus write enable from datapath
//   memRead        bus read enable from datapath
//   dmem_readData  read data from dmem
//   readData       read data returned to datapath (combinational)
//   dm_writeEnable write enable forwarded to dmem (never for I/O hits)
//   dm_readEnable  read enable forwarded to dmem (never for I/O hits)
//   i_sw           raw asynchronous board switches
//   o_led          LED register
//   o_disp         display register
module mmio_responder #(
    parameter int                N          = 64,
    parameter logic [N-1:0]      IO_BASE    = 64'h8000,
    parameter int                DEB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] writeData,
    input  logic         memWrite,
    input  logic         memRead,
    input  logic [N-1:0] dmem_readData,
    output logic [N-1:0] readData,
    output logic         dm_writeEnable,
    output logic         dm_readEnable,
    input  logic [15:0]  i_sw,
    output logic [15:0]  o_led,
    output logic [15:0]  o_disp
);

    localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    localparam logic [4:0] SEL_LED     = 5'd0;
    localparam logic [4:0] SEL_SW      = 5'd1;
    localparam logic [4:0] SEL_SW_EDGE = 5'd2;
    localparam logic [4:0] SEL_CYCLE   = 5'd3;
    localparam logic [4:0] SEL_DISP    = 5'd4;

    logic             io_hit;
    logic [4:0]       reg_sel;
    logic             wr_en;
    logic [N-1:0]     io_rdata;

    logic [15:0]      sw_s1;
    logic [15:0]      sw_s2;
    logic [15:0]      cand;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      sw_deb;
    logic [15:0]      sw_deb_nxt;
    logic [15:0]      sw_edge;
    logic [15:0]      edge_clr;
    logic [N-1:0]     cycle;

    // Byte offset within a register is don't-care; the word select is addr[7:3].
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, addr[2:0]};

    assign io_hit  = (addr[N-1:8] == IO_BASE[N-1:8]);
    assign reg_sel = addr[7:3];
    assign wr_en   = memWrite && io_hit;

    assign dm_writeEnable = memWrite && !io_hit;
    assign dm_readEnable  = memRead  && !io_hit;

    // Debounced value as it will be after this edge; SW_EDGE needs it to flag
    // a rise on the same edge that SW changes.
    always_comb begin
        sw_deb_nxt = sw_deb;
        if ((sw_s2 == cand) && (cnt == CNT_MAX)) begin
            sw_deb_nxt = cand;
        end
    end

    always_comb begin
        edge_clr = 16'h0000;
        if (wr_en && (reg_sel == SEL_SW_EDGE)) begin
            edge_clr = writeData[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1   <= 16'h0000;
            sw_s2   <= 16'h0000;
            cand    <= 16'h0000;
            cnt     <= '0;
            sw_deb  <= 16'h0000;
            sw_edge <= 16'h0000;
        end else begin
            sw_s1 <= i_sw;
            sw_s2 <= sw_s1;
            // Any change in the synchronized value restarts the stability count.
            if (sw_s2 != cand) begin
                cand <= sw_s2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            sw_deb <= sw_deb_nxt;
            // Set is ORed in after the clear so a simultaneous rise wins.
            sw_edge <= (sw_edge & ~edge_clr) | (sw_deb_nxt & ~sw_deb);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_led  <= 16'h0000;
            o_disp <= 16'h0000;
            cycle  <= '0;
        end else begin
            if (wr_en && (reg_sel == SEL_LED)) begin
                o_led <= writeData[15:0];
            end
            if (wr_en && (reg_sel == SEL_DISP)) begin
                o_disp <= writeData[15:0];
            end
            if (wr_en && (reg_sel == SEL_CYCLE)) begin
                cycle <= writeData;
            end else begin
                cycle <= cycle + 1'b1;
            end
        end
    end

    // Reads present the current (pre-write) register contents.
    always_comb begin
        io_rdata = '0;
        case (reg_sel)
            SEL_LED:     io_rdata = {{(N-16){1'b0}}, o_led};
            SEL_SW:      io_rdata = {{(N-16){1'b0}}, sw_deb};
            SEL_SW_EDGE: io_rdata = {{(N-16){1'b0}}, sw_edge};
            SEL_CYCLE:   io_rdata = cycle;
            SEL_DISP:    io_rdata = {{(N-16){1'b0}}, o_disp};
            default:     io_rdata = '0;
        endcase
    end

    assign readData = io_hit ? io_rdata : dmem_readData;

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - directed bench for mmio_responder
module tb_mmio_responder;

    logic        clk;
    logic        reset;
    logic [63:0] addr;
    logic [63:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [63:0] dmem_readData;
    logic [63:0] readData;
    logic        dm_writeEnable;
    logic        dm_readEnable;
    logic [15:0] i_sw;
    logic [15:0] o_led;
    logic [15:0] o_disp;

    int vec_cnt;
    int err_cnt;

    mmio_responder #(
        .N(64),
        .IO_BASE(64'h8000),
        .DEB_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .writeData(writeData),
        .memWrite(memWrite),
        .memRead(memRead),
        .dmem_readData(dmem_readData),
        .readData(readData),
        .dm_writeEnable(dm_writeEnable),
        .dm_readEnable(dm_readEnable),
        .i_sw(i_sw),
        .o_led(o_led),
        .o_disp(o_disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wd;
        logic        we;
        logic        re;
        logic [63:0] dmem;
        logic [63:0] exp_rd;
        logic        exp_dwe;
        logic        exp_dre;
        logic [15:0] exp_led;
        logic [15:0] exp_disp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [63:0] a, input logic [63:0] exp);
        addr = a;
        #1;
        check(name, readData, exp);
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        addr      = a;
        writeData = d;
        memWrite  = 1'b1;
        step();
        memWrite  = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        reset = 1'b1;
        addr = '0;
        writeData = '0;
        memWrite = 1'b0;
        memRead = 1'b0;
        dmem_readData = '0;
        i_sw = 16'h0000;

        //            addr         wd                     we    re    dmem                   exp_rd                 dwe   dre   led       disp
        vecs[0]  = '{64'h8000, 64'h0,                  1'b0, 1'b1, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{64'h8008, 64'h0,                  1'b0, 1'b1, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{64'h8010, 64'h0,                  1'b0, 1'b1, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[3]  = '{64'h8020, 64'h0,                  1'b0, 1'b1, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[4]  = '{64'h8000, 64'hA5A5,               1'b1, 1'b1, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'hA5A5, 16'h0000};
        vecs[5]  = '{64'h8020, 64'h1234,               1'b1, 1'b1, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'hA5A5, 16'h1234};
        vecs[6]  = '{64'h0040, 64'hFFFF,               1'b1, 1'b0, 64'hDEAD,              64'hDEAD,              1'b1, 1'b0, 16'hA5A5, 16'h1234};
        vecs[7]  = '{64'h0100, 64'h0,                  1'b0, 1'b1, 64'h1122334455667788,  64'h1122334455667788,  1'b0, 1'b1, 16'hA5A5, 16'h1234};
        vecs[8]  = '{64'h80F8, 64'h0,                  1'b0, 1'b1, 64'h99,                64'h0,                 1'b0, 1'b0, 16'hA5A5, 16'h1234};
        vecs[9]  = '{64'h8005, 64'h0,                  1'b0, 1'b1, 64'h0,                 64'hA5A5,              1'b0, 1'b0, 16'hA5A5, 16'h1234};
        vecs[10] = '{64'h8008, 64'hFFFF,               1'b1, 1'b0, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'hA5A5, 16'h1234};
        vecs[11] = '{64'h8008, 64'h0,                  1'b0, 1'b1, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'hA5A5, 16'h1234};
        vecs[12] = '{64'h80F8, 64'h1,                  1'b1, 1'b0, 64'h0,                 64'h0,                 1'b0, 1'b0, 16'hA5A5, 16'h1234};
        vecs[13] = '{64'h8020, 64'h0,                  1'b0, 1'b0, 64'h0,                 64'h1234,              1'b0, 1'b0, 16'hA5A5, 16'h1234};
        vecs[14] = '{64'h8000, 64'hFFFFFFFFFFFF5A5A,   1'b1, 1'b0, 64'h0,                 64'hA5A5,              1'b0, 1'b0, 16'h5A5A, 16'h1234};
        vecs[15] = '{64'h8000, 64'h0,                  1'b0, 1'b1, 64'h0,                 64'h5A5A,              1'b0, 1'b0, 16'h5A5A, 16'h1234};

        step();
        step();
        reset = 1'b0;
        check("rst_led", {48'h0, o_led}, 64'h0);
        check("rst_disp", {48'h0, o_disp}, 64'h0);

        for (int i = 0; i < 16; i++) begin
            addr          = vecs[i].addr;
            writeData     = vecs[i].wd;
            memWrite      = vecs[i].we;
            memRead       = vecs[i].re;
            dmem_readData = vecs[i].dmem;
            #1;
            check($sformatf("v%0d_rd", i), readData, vecs[i].exp_rd);
            check($sformatf("v%0d_dwe", i), {63'h0, dm_writeEnable}, {63'h0, vecs[i].exp_dwe});
            check($sformatf("v%0d_dre", i), {63'h0, dm_readEnable}, {63'h0, vecs[i].exp_dre});
            step();
            check($sformatf("v%0d_led", i), {48'h0, o_led}, {48'h0, vecs[i].exp_led});
            check($sformatf("v%0d_disp", i), {48'h0, o_disp}, {48'h0, vecs[i].exp_disp});
        end
        memWrite      = 1'b0;
        memRead       = 1'b0;
        dmem_readData = '0;

        // Debounce latency: stable from before edge 1, visible after edge 19.
        addr = 64'h8008;
        i_sw = 16'h0003;
        for (int e = 1; e <= 19; e++) begin
            step();
            check($sformatf("deb_e%0d", e), readData, (e < 19) ? 64'h0 : 64'h3);
        end
        rd_chk("edge_after_rise", 64'h8010, 64'h3);
        wr(64'h8010, 64'h1);
        rd_chk("edge_clr_b0", 64'h8010, 64'h2);

        // Short glitch on bit 5 must never reach SW or SW_EDGE.
        i_sw = 16'h0023;
        for (int k = 0; k < 10; k++) step();
        i_sw = 16'h0003;
        for (int k = 0; k < 25; k++) step();
        rd_chk("glitch_sw", 64'h8008, 64'h3);
        rd_chk("glitch_edge", 64'h8010, 64'h2);

        // Set beats clear when both land on bit 1 in the same edge.
        i_sw = 16'h0001;
        for (int k = 0; k < 22; k++) step();
        rd_chk("fall_sw", 64'h8008, 64'h1);
        wr(64'h8010, 64'h3);
        rd_chk("edge_all_clr", 64'h8010, 64'h0);
        i_sw = 16'h0003;
        for (int k = 0; k < 18; k++) step();
        rd_chk("pre_rise_sw", 64'h8008, 64'h1);
        rd_chk("pre_rise_edge", 64'h8010, 64'h0);
        wr(64'h8010, 64'h2);
        rd_chk("set_wins_edge", 64'h8010, 64'h2);
        rd_chk("set_wins_sw", 64'h8008, 64'h3);

        // CYCLE load and wrap.
        wr(64'h8018, 64'hFFFFFFFFFFFFFFFE);
        rd_chk("cyc_load", 64'h8018, 64'hFFFFFFFFFFFFFFFE);
        step();
        check("cyc_max", readData, 64'hFFFFFFFFFFFFFFFF);
        step();
        check("cyc_wrap", readData, 64'h0);

        // Reset during debounce with CYCLE=0x55.
        i_sw = 16'h0100;
        for (int k = 0; k < 5; k++) step();
        wr(64'h8018, 64'h55);
        rd_chk("cyc_55", 64'h8018, 64'h55);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd_chk("rr_led", 64'h8000, 64'h0);
        rd_chk("rr_sw", 64'h8008, 64'h0);
        rd_chk("rr_edge", 64'h8010, 64'h0);
        rd_chk("rr_cyc", 64'h8018, 64'h0);
        rd_chk("rr_disp", 64'h8020, 64'h0);
        check("rr_o_led", {48'h0, o_led}, 64'h0);
        check("rr_o_disp", {48'h0, o_disp}, 64'h0);
        addr = 64'h8008;
        for (int e = 1; e <= 19; e++) begin
            step();
            if (e >= 18) check($sformatf("rr_deb_e%0d", e), readData, (e < 19) ? 64'h0 : 64'h100);
        end
        rd_chk("rr_edge_set", 64'h8010, 64'h100);
        rd_chk("rr_cyc_cnt", 64'h8018, 64'h13);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
